// File: rtl/config_chain_pkg.sv
// Shared types and helpers for the multi-chain configuration shifter.
package config_chain_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_SETUP,
        ST_HIGH,
        ST_PUSH,
        ST_LOAD,
        ST_DONE
    } state_t;

    localparam int unsigned DEF_CHAIN_WIDTH = 5164;
    localparam int unsigned DEF_WORD_WIDTH  = 32;

    function automatic int unsigned idx_width(input int unsigned chain_width);
        return $clog2(chain_width + 1);
    endfunction

    function automatic int unsigned wcnt_width(input int unsigned chain_width,
                                               input int unsigned word_width);
        return $clog2((chain_width + word_width - 1) / word_width + 1);
    endfunction

    localparam int unsigned BIT_IDX_W = idx_width(DEF_CHAIN_WIDTH);
    localparam int unsigned WORD_CNT_W = wcnt_width(DEF_CHAIN_WIDTH, DEF_WORD_WIDTH);

    function automatic logic [31:0] sat_div(input logic [31:0] div);
        return (div == 32'd0) ? 32'd1 : div;
    endfunction

    // Zero and oversize requests both mean "the whole chain".
    function automatic logic [31:0] sat_bits(input logic [31:0] bits, input logic [31:0] max_bits);
        return (bits == 32'd0 || bits > max_bits) ? max_bits : bits;
    endfunction

endpackage

// File: rtl/config_chain_shifter_tick.sv
// Phase timer: down-counter that flags the last cycle of a clk_div-long phase.
module config_clk_tick
    import config_chain_pkg::*;
#(
    parameter int W = 17
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         clr_i,
    input  logic         load_i,
    input  logic [W-1:0] period_i,
    output logic         tick_o
);

    logic [W-1:0] cnt_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else if (clr_i) begin
            cnt_q <= '0;
        end else if (load_i) begin
            cnt_q <= period_i - W'(1);
        end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - W'(1);
        end
    end

    assign tick_o = !clr_i && (cnt_q == '0);

endmodule

// File: rtl/config_chain_shifter.sv
// Drives NUM_CHAINS configuration shift chains from a word stream and returns
// the captured ConfigOut bits as a word stream.
//
// state | meaning
// IDLE  | waiting for start
// FETCH | waiting for the next write word
// SETUP | ConfigClk low, ConfigIn presented
// HIGH  | ConfigClk high, ConfigOut captured on entry
// PUSH  | readback word offered, chain clock stalled
// LOAD  | ConfigLoad strobe for 2*clk_div cycles
// DONE  | one-cycle completion pulse
module config_chain_shifter
    import config_chain_pkg::*;
#(
    parameter int NUM_CHAINS  = 2,
    parameter int CHAIN_WIDTH = 5164,
    parameter int WORD_WIDTH  = 32,
    parameter int DIV_WIDTH   = 16
) (
    input  logic                                                    S_AXI_ACLK,
    input  logic                                                    S_AXI_ARESET,
    input  logic                                                    start,
    input  logic                                                    abort,
    input  logic [((NUM_CHAINS > 1) ? $clog2(NUM_CHAINS) : 1)-1:0] chain_sel,
    input  logic [$clog2(CHAIN_WIDTH+1)-1:0]                        bit_count,
    input  logic [DIV_WIDTH-1:0]                                    clk_div,
    input  logic                                                    load_en,
    input  logic [WORD_WIDTH-1:0]                                   s_wdata,
    input  logic                                                    s_wvalid,
    output logic                                                    s_wready,
    output logic [WORD_WIDTH-1:0]                                   m_rdata,
    output logic                                                    m_rvalid,
    input  logic                                                    m_rready,
    output logic                                                    busy,
    output logic                                                    done,
    output logic                                                    aborted,
    output logic [NUM_CHAINS-1:0]                                   ConfigClk,
    output logic [NUM_CHAINS-1:0]                                   ConfigIn,
    output logic [NUM_CHAINS-1:0]                                   ConfigLoad,
    input  logic [NUM_CHAINS-1:0]                                   ConfigOut
);

    localparam int SEL_W = (NUM_CHAINS > 1) ? $clog2(NUM_CHAINS) : 1;
    localparam int BC_W  = idx_width(CHAIN_WIDTH);
    localparam int POS_W = (WORD_WIDTH > 1) ? $clog2(WORD_WIDTH) : 1;
    localparam int TMR_W = DIV_WIDTH + 1;

    state_t                  state_q;
    logic [SEL_W-1:0]        sel_q;
    logic [BC_W-1:0]         nbits_q;
    logic [BC_W-1:0]         idx_q;
    logic [DIV_WIDTH-1:0]    div_q;
    logic                    load_en_q;
    logic [POS_W-1:0]        pos_q;
    logic [WORD_WIDTH-1:0]   wbuf_q;
    logic [WORD_WIDTH-1:0]   rbuf_q;
    logic                    aborted_q;
    logic                    done_q;
    logic                    busy_q;
    logic                    wready_q;
    logic                    rvalid_q;
    logic [NUM_CHAINS-1:0]   cclk_q;
    logic [NUM_CHAINS-1:0]   cin_q;
    logic [NUM_CHAINS-1:0]   cload_q;

    logic                    tick;
    logic                    tmr_clr;
    logic                    tmr_load;
    logic [TMR_W-1:0]        tmr_period;
    logic [BC_W-1:0]         bits_sat;
    logic [BC_W-1:0]         idx_nx;
    logic [DIV_WIDTH-1:0]    div_sat;
    logic [POS_W-1:0]        pos_nx;
    logic                    word_end;

    assign bits_sat = BC_W'(sat_bits(32'(bit_count), 32'(CHAIN_WIDTH)));
    assign div_sat  = DIV_WIDTH'(sat_div(32'(clk_div)));
    assign idx_nx   = idx_q + BC_W'(1);
    assign pos_nx   = pos_q + POS_W'(1);
    assign word_end = (pos_q == POS_W'(WORD_WIDTH - 1)) || (idx_nx == nbits_q);

    // Timer restarts on every entry into a timed phase; LOAD runs two half-periods.
    assign tmr_clr    = (state_q == ST_IDLE);
    assign tmr_load   = (state_q == ST_FETCH && s_wvalid)
                      || ((state_q == ST_SETUP || state_q == ST_HIGH) && tick)
                      || (state_q == ST_PUSH && m_rready);
    assign tmr_period = (state_q == ST_PUSH) ? {div_q, 1'b0} : {1'b0, div_q};

    config_clk_tick #(.W(TMR_W)) u_tick (
        .clk_i    (S_AXI_ACLK),
        .rst_i    (S_AXI_ARESET),
        .clr_i    (tmr_clr),
        .load_i   (tmr_load),
        .period_i (tmr_period),
        .tick_o   (tick)
    );

    always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
        if (S_AXI_ARESET) begin
            state_q   <= ST_IDLE;
            sel_q     <= '0;
            nbits_q   <= '0;
            idx_q     <= '0;
            div_q     <= '0;
            load_en_q <= 1'b0;
            pos_q     <= '0;
            wbuf_q    <= '0;
            rbuf_q    <= '0;
            aborted_q <= 1'b0;
            done_q    <= 1'b0;
            busy_q    <= 1'b0;
            wready_q  <= 1'b0;
            rvalid_q  <= 1'b0;
            cclk_q    <= '0;
            cin_q     <= '0;
            cload_q   <= '0;
        end else if (abort) begin
            state_q   <= ST_IDLE;
            aborted_q <= 1'b1;
            done_q    <= 1'b0;
            busy_q    <= 1'b0;
            wready_q  <= 1'b0;
            rvalid_q  <= 1'b0;
            cclk_q    <= '0;
            cin_q     <= '0;
            cload_q   <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        sel_q     <= chain_sel;
                        nbits_q   <= bits_sat;
                        div_q     <= div_sat;
                        load_en_q <= load_en;
                        idx_q     <= '0;
                        pos_q     <= '0;
                        rbuf_q    <= '0;
                        aborted_q <= 1'b0;
                        busy_q    <= 1'b1;
                        wready_q  <= 1'b1;
                        state_q   <= ST_FETCH;
                    end
                end
                ST_FETCH: begin
                    if (s_wvalid) begin
                        wbuf_q       <= s_wdata;
                        wready_q     <= 1'b0;
                        cin_q[sel_q] <= s_wdata[0];
                        state_q      <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    if (tick) begin
                        cclk_q[sel_q] <= 1'b1;
                        rbuf_q[pos_q] <= ConfigOut[sel_q];
                        state_q       <= ST_HIGH;
                    end
                end
                ST_HIGH: begin
                    if (tick) begin
                        cclk_q[sel_q] <= 1'b0;
                        idx_q         <= idx_nx;
                        if (word_end) begin
                            pos_q        <= '0;
                            cin_q[sel_q] <= 1'b0;
                            rvalid_q     <= 1'b1;
                            state_q      <= ST_PUSH;
                        end else begin
                            pos_q        <= pos_nx;
                            cin_q[sel_q] <= wbuf_q[pos_nx];
                            state_q      <= ST_SETUP;
                        end
                    end
                end
                ST_PUSH: begin
                    if (m_rready) begin
                        rvalid_q <= 1'b0;
                        rbuf_q   <= '0;
                        if (idx_q == nbits_q) begin
                            if (load_en_q) begin
                                cload_q[sel_q] <= 1'b1;
                                state_q        <= ST_LOAD;
                            end else begin
                                done_q  <= 1'b1;
                                state_q <= ST_DONE;
                            end
                        end else begin
                            wready_q <= 1'b1;
                            state_q  <= ST_FETCH;
                        end
                    end
                end
                ST_LOAD: begin
                    if (tick) begin
                        cload_q[sel_q] <= 1'b0;
                        done_q         <= 1'b1;
                        state_q        <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign s_wready   = wready_q;
    assign m_rdata    = rbuf_q;
    assign m_rvalid   = rvalid_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign aborted    = aborted_q;
    assign ConfigClk  = cclk_q;
    assign ConfigIn   = cin_q;
    assign ConfigLoad = cload_q;

endmodule

// File: tb/tb_config_chain_shifter.sv
// Randomised bench for config_chain_shifter: loopback chains with a per-chain
// inversion, checked against a word/bit-level model of the shift operation.
module tb_config_chain_shifter;

    localparam int NC  = 2;
    localparam int CW  = 5164;
    localparam int WW  = 32;
    localparam int DW  = 16;
    localparam int LIM = 20000;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic [0:0]    chain_sel = '0;
    logic [12:0]   bit_count = '0;
    logic [DW-1:0] clk_div = '0;
    logic          load_en = 1'b0;
    logic [WW-1:0] s_wdata = '0;
    logic          s_wvalid = 1'b0;
    logic          s_wready;
    logic [WW-1:0] m_rdata;
    logic          m_rvalid;
    logic          m_rready = 1'b0;
    logic          busy, done, aborted;
    logic [NC-1:0] ConfigClk, ConfigIn, ConfigLoad, ConfigOut;
    logic [NC-1:0] flip = '0;

    assign ConfigOut = ConfigIn ^ flip;

    config_chain_shifter #(.NUM_CHAINS(NC), .CHAIN_WIDTH(CW), .WORD_WIDTH(WW), .DIV_WIDTH(DW)) dut (
        .S_AXI_ACLK(clk), .S_AXI_ARESET(rst), .start(start), .abort(abort),
        .chain_sel(chain_sel), .bit_count(bit_count), .clk_div(clk_div), .load_en(load_en),
        .s_wdata(s_wdata), .s_wvalid(s_wvalid), .s_wready(s_wready),
        .m_rdata(m_rdata), .m_rvalid(m_rvalid), .m_rready(m_rready),
        .busy(busy), .done(done), .aborted(aborted),
        .ConfigClk(ConfigClk), .ConfigIn(ConfigIn), .ConfigLoad(ConfigLoad), .ConfigOut(ConfigOut)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Operation model state
    logic [WW-1:0] op_words[$];
    int            wstall_q[$];
    int            rstall_q[$];
    bit            op_flip;
    bit            mon_on = 1'b0;
    bit            clk_prev = 1'b0;
    int            msel = 0, mdiv = 1;
    int            edge_cnt, last_edge_cyc, load_cyc, done_cnt, done_cyc;
    int            stall_viol, other_nz, last_hs_cyc;

    function automatic logic exp_bit(input int k);
        logic [WW-1:0] w;
        w = op_words[k / WW];
        return w[k % WW];
    endfunction

    always @(negedge clk) begin
        if (mon_on) begin
            if (ConfigClk[msel] && !clk_prev) begin
                check_eq("cin_bit", 64'(ConfigIn[msel]), 64'(exp_bit(edge_cnt)));
                if (edge_cnt % WW != 0)
                    check_eq("bit_period", 64'(cyc - last_edge_cyc), 64'(2 * mdiv));
                last_edge_cyc = cyc;
                edge_cnt++;
            end
            clk_prev = ConfigClk[msel];
            if (ConfigLoad[msel]) load_cyc++;
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            for (int c = 0; c < NC; c++)
                if (c != msel && (ConfigClk[c] || ConfigIn[c] || ConfigLoad[c])) other_nz++;
            if (((s_wready && !s_wvalid) || (m_rvalid && !m_rready)) && ConfigClk[msel])
                stall_viol++;
        end
    end

    task automatic fill_random(input int nw);
        op_words.delete(); wstall_q.delete(); rstall_q.delete();
        for (int w = 0; w < nw; w++) begin
            op_words.push_back($urandom);
            wstall_q.push_back($urandom_range(0, 4));
            rstall_q.push_back($urandom_range(0, 4));
        end
    endtask

    task automatic run_op(input int sel, input int bc, input int dv, input bit ld, input bit poke);
        int nb, nw, edv, t;
        nb  = (bc == 0 || bc > CW) ? CW : bc;
        nw  = (nb + WW - 1) / WW;
        edv = (dv == 0) ? 1 : dv;
        msel = sel; mdiv = edv; edge_cnt = 0; load_cyc = 0; done_cnt = 0;
        stall_viol = 0; other_nz = 0; clk_prev = 1'b0; op_flip = flip[sel];
        @(negedge clk);
        chain_sel = 1'(sel); bit_count = 13'(bc); clk_div = DW'(dv); load_en = ld;
        start = 1'b1; mon_on = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check_eq("busy_after_start", 64'(busy), 64'd1);
        check_eq("aborted_cleared", 64'(aborted), 64'd0);
        fork
            begin : writer
                for (int w = 0; w < nw; w++) begin
                    int tw;
                    tw = 0;
                    while (!s_wready && tw < LIM) begin @(negedge clk); tw++; end
                    check_eq("wr_ready_seen", 64'(s_wready), 64'd1);
                    repeat ((w < wstall_q.size()) ? wstall_q[w] : 0) @(negedge clk);
                    s_wdata = op_words[w]; s_wvalid = 1'b1;
                    @(negedge clk);
                    s_wvalid = 1'b0; s_wdata = $urandom;
                    if (poke && w == 0) begin
                        start = 1'b1; chain_sel = ~chain_sel;
                        @(negedge clk);
                        start = 1'b0;
                    end
                end
            end
            begin : reader
                for (int w = 0; w < nw; w++) begin
                    int tr, vb;
                    logic [WW-1:0] expw;
                    tr = 0;
                    while (!m_rvalid && tr < LIM) begin @(negedge clk); tr++; end
                    check_eq("rd_valid_seen", 64'(m_rvalid), 64'd1);
                    repeat ((w < rstall_q.size()) ? rstall_q[w] : 0) @(negedge clk);
                    m_rready = 1'b1;
                    vb = nb - w * WW;
                    if (vb > WW) vb = WW;
                    expw = op_words[w] ^ (op_flip ? 32'hFFFF_FFFF : 32'h0);
                    if (vb < WW) expw = expw & ((32'd1 << vb) - 32'd1);
                    check_eq("rdata", 64'(m_rdata), 64'(expw));
                    last_hs_cyc = cyc;
                    @(negedge clk);
                    m_rready = 1'b0;
                end
            end
        join
        t = 0;
        while (done_cnt == 0 && t < LIM) begin @(negedge clk); t++; end
        repeat (3) @(negedge clk);
        mon_on = 1'b0;
        check_eq("edge_count", 64'(edge_cnt), 64'(nb));
        check_eq("done_pulses", 64'(done_cnt), 64'd1);
        check_eq("done_latency", 64'(done_cyc - last_hs_cyc), 64'(ld ? 2 * edv + 1 : 1));
        check_eq("load_cycles", 64'(load_cyc), 64'(ld ? 2 * edv : 0));
        check_eq("other_chains_quiet", 64'(other_nz), 64'd0);
        check_eq("stall_clk_low", 64'(stall_viol), 64'd0);
        check_eq("busy_after_done", 64'(busy), 64'd0);
    endtask

    initial begin
        int n, t, dseen;
        bit prev;

        repeat (3) @(negedge clk);
        check_eq("reset_outputs",
                 {21'd0, m_rdata, ConfigClk, ConfigIn, ConfigLoad, s_wready, m_rvalid, busy, done, aborted},
                 64'd0);
        rst = 1'b0;
        @(negedge clk);

        // Basic shift of 0xA5
        flip = 2'b00;
        op_words = '{32'h0000_00A5}; wstall_q = '{0}; rstall_q = '{0};
        run_op(0, 8, 2, 1'b0, 1'b0);

        // Two words with ConfigLoad on chain 1
        op_words = '{32'hFFFF_0000, 32'h0000_00AB}; wstall_q = '{0, 0}; rstall_q = '{0, 0};
        run_op(1, 40, 1, 1'b1, 1'b0);

        // Back-pressure on both streams
        op_words = '{32'hFFFF_0000, 32'h0000_00AB}; wstall_q = '{0, 50}; rstall_q = '{30, 0};
        run_op(1, 40, 1, 1'b1, 1'b0);

        // Abort during bit 5 of 8
        @(negedge clk);
        chain_sel = 1'b0; bit_count = 13'd8; clk_div = 16'd2; load_en = 1'b0;
        s_wdata = 32'h0000_005A; s_wvalid = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        s_wvalid = 1'b0;
        n = 0; prev = 1'b0; t = 0;
        while (n < 5 && t < LIM) begin
            @(negedge clk);
            if (ConfigClk[0] && !prev) n++;
            prev = ConfigClk[0];
            t++;
        end
        check_eq("abort_edges_before", 64'(n), 64'd5);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check_eq("abort_outputs", {53'd0, ConfigClk, ConfigIn, ConfigLoad, s_wready, m_rvalid, busy, done}, 64'd0);
        check_eq("abort_sticky", 64'(aborted), 64'd1);
        dseen = 0;
        repeat (20) begin @(negedge clk); if (done || busy) dseen++; end
        check_eq("abort_no_done", 64'(dseen), 64'd0);

        // Restart after abort clears aborted
        flip = 2'b01;
        fill_random(2);
        run_op(0, 50, 2, 1'b0, 1'b0);

        // Abort in IDLE, then abort together with start
        @(negedge clk); abort = 1'b1;
        @(negedge clk); abort = 1'b0;
        check_eq("abort_idle_sets", 64'(aborted), 64'd1);
        start = 1'b1; abort = 1'b1;
        @(negedge clk); start = 1'b0; abort = 1'b0;
        check_eq("abort_beats_start", 64'(busy), 64'd0);
        @(negedge clk);
        check_eq("abort_beats_start_state", 64'(busy | s_wready), 64'd0);

        // clk_div=0 behaves as 1; bit_count=1
        flip = 2'b10;
        fill_random(1);
        run_op(1, 20, 0, 1'b1, 1'b0);
        fill_random(1);
        run_op(1, 1, 3, 1'b0, 1'b0);

        // Randomised operations, one with a start issued while busy
        for (int i = 0; i < 8; i++) begin
            int bc;
            bc = $urandom_range(1, 100);
            flip = 2'($urandom);
            fill_random((bc + WW - 1) / WW);
            run_op($urandom_range(0, 1), bc, $urandom_range(0, 3), 1'($urandom), i == 2);
        end

        // bit_count=0 means the full chain
        flip = 2'($urandom);
        fill_random((CW + WW - 1) / WW);
        for (int w = 0; w < wstall_q.size(); w++) begin wstall_q[w] = 0; rstall_q[w] = 0; end
        run_op(0, 0, 1, 1'b0, 1'b0);

        // Asynchronous reset while ConfigClk is high
        @(negedge clk);
        chain_sel = 1'b1; bit_count = 13'd8; clk_div = 16'd3; load_en = 1'b1;
        s_wdata = $urandom; s_wvalid = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        s_wvalid = 1'b0;
        t = 0;
        while (!ConfigClk[1] && t < LIM) begin @(negedge clk); t++; end
        check_eq("reset_test_high_seen", 64'(ConfigClk[1]), 64'd1);
        #2 rst = 1'b1;
        #1;
        check_eq("async_reset_outputs",
                 {21'd0, m_rdata, ConfigClk, ConfigIn, ConfigLoad, s_wready, m_rvalid, busy, done, aborted},
                 64'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check_eq("post_reset_idle", 64'(busy | s_wready | ConfigClk[1]), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/config_chain_shifter.md
Name: config_chain_shifter

Overview:
- Parametrised successor to the single-chain configuration shift-register interface.
- Drives NUM_CHAINS independent chip configuration shift registers (ConfigClk/ConfigIn/ConfigLoad per chain) with a runtime-programmable bit count and clock divider.
- Streams write data in and captured ConfigOut readback out over valid/ready word ports, with back-pressure stalling the chain clock.
- Sits between the AXI register/FIFO front end and the chip pins.

Parameters:
- NUM_CHAINS, 2, number of independent config chains (1..8).
- CHAIN_WIDTH, 5164, maximum bits per shift operation.
- WORD_WIDTH, 32, width of the data stream words.
- DIV_WIDTH, 16, width of the half-period divider value.

Ports:
- S_AXI_ACLK  in  1  system clock.
- S_AXI_ARESET  in  1  reset; asynchronous, active-high.
- start  in  1  one-cycle pulse; begins an operation; honoured only when busy=0.
- abort  in  1  one-cycle pulse; terminates any operation.
- chain_sel  in  $clog2(NUM_CHAINS) (min 1)  target chain; latched at start.
- bit_count  in  $clog2(CHAIN_WIDTH+1)  bits to shift; 0 or >CHAIN_WIDTH is treated as CHAIN_WIDTH; latched at start.
- clk_div  in  DIV_WIDTH  ConfigClk half-period in S_AXI_ACLK cycles; 0 is treated as 1; latched at start.
- load_en  in  1  issue a ConfigLoad pulse after shifting; latched at start.
- s_wdata  in  WORD_WIDTH  shift-in word; LSB is shifted first.
- s_wvalid  in  1, s_wready  out  1  write-stream handshake.
- m_rdata  out  WORD_WIDTH  captured readback word.
- m_rvalid  out  1, m_rready  in  1  readback-stream handshake.
- busy  out  1  high from the cycle after start until done/abort.
- done  out  1  one-cycle pulse on normal completion.
- aborted  out  1  sticky; cleared by the next accepted start.
- ConfigClk  out  NUM_CHAINS  chain shift clocks.
- ConfigIn  out  NUM_CHAINS  chain serial data.
- ConfigLoad  out  NUM_CHAINS  chain parallel-load strobes.
- ConfigOut  in  NUM_CHAINS  chain serial outputs.

Behaviour:
- Reset values: all outputs 0, state IDLE, counters 0.
- Unselected chains hold ConfigClk/ConfigIn/ConfigLoad at 0 at all times.
- States:
  - IDLE: on start, latch parameters, clear aborted, go to FETCH.
  - FETCH: s_wready=1; on s_wvalid&s_wready, load the word into the shift buffer and go to SETUP.
  - SETUP: ConfigClk=0; ConfigIn = current buffer bit; hold clk_div cycles, then go to HIGH.
  - HIGH: ConfigClk=1 for clk_div cycles. On the first cycle of HIGH (rising edge), sample ConfigOut[sel] into the readback buffer at bit position i%WORD_WIDTH.
    - After HIGH, increment the bit index i.
    - If i==bit_count, or i%WORD_WIDTH==0: go to PUSH.
    - Otherwise: go to SETUP.
  - PUSH: m_rvalid=1 with the readback word; unfilled upper bits are 0. ConfigClk stays 0 while m_rready=0 (stall).
    - On handshake, if i==bit_count: go to LOAD if load_en, else DONE.
    - Otherwise: go to FETCH.
  - LOAD: ConfigLoad[sel]=1 for 2*clk_div cycles, then go to DONE.
  - DONE: done=1 for one cycle, then go to IDLE.
- Word count = ceil(bit_count/WORD_WIDTH). Extra bits beyond bit_count in the last write word are discarded.
- Stalls: FETCH with s_wvalid=0, or PUSH with m_rready=0, keeps ConfigClk low indefinitely. No error is raised and no bit is lost.
- Unstalled bit period is exactly 2*clk_div cycles.
- ConfigIn changes only in the first cycle of SETUP, i.e. at least clk_div cycles before the rising edge.
- ConfigIn holds its value through HIGH and returns to 0 in PUSH/LOAD/IDLE.
- abort in any state: next cycle goes to IDLE, all chain outputs 0, s_wready=0, m_rvalid=0, aborted=1, done not pulsed.
- abort in IDLE: still sets aborted.
- abort and start in the same cycle: abort wins and start is ignored.
- start while busy: ignored.
- Asynchronous reset mid-operation forces the reset values immediately.
- bit_count=1: one word fetched, one edge, readback word = {0..., bit}.

Decomposition:
- Shared package config_chain_pkg holds:
  - state enum (IDLE, FETCH, SETUP, HIGH, PUSH, LOAD, DONE);
  - bit-index and word-count width localparams;
  - saturation helpers for clk_div and bit_count.
- Sub-module config_clk_tick: loadable down-counter that produces a phase-end tick every clk_div cycles; restarted on each state entry; held in reset in IDLE.

Test Plan:
- Basic shift: chain 0, bit_count=8, clk_div=2, load_en=0, word 0xA5, ConfigOut tied to ConfigIn.
  - ConfigIn pattern 1,0,1,0,0,1,0,1 sampled at 8 rising edges, each edge 4 cycles apart.
  - m_rdata=0x000000A5; done 1 cycle after the handshake.
- Multi-word with load: chain 1, bit_count=40, clk_div=1, load_en=1, words 0xFFFF0000 then 0x000000AB.
  - Two reads: 0xFFFF0000, then 0x000000AB (upper bits zero).
  - ConfigLoad[1] high 2 cycles; chain 0 outputs stay 0.
- Back-pressure: s_wvalid deasserted 50 cycles before the second word, m_rready low 30 cycles.
  - ConfigClk stays low throughout both stalls; edge count still 40; readback data unchanged.
- Abort: abort during bit 5 of 8.
  - Next cycle all outputs 0, aborted=1, no done.
  - A following start clears aborted and completes normally.
- Boundaries: clk_div=0 behaves as 1; bit_count=0 shifts 5164 bits (162 words, last word 12 valid bits); start while busy is ignored.
- Reset: S_AXI_ARESET asserted mid-HIGH returns every output to 0 without waiting for a clock edge.
